// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller.
// Turns a load/store from the EX/MEM register into one D-cache request,
// freezes the pipeline with cache_stall while the request is outstanding,
// aligns store data onto byte lanes, extracts and extends load data, and
// reports misaligned accesses without touching the cache.
module mem_access_unit #(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [2:0]             funct3,
    input  logic [31:0]            addr,
    input  logic [31:0]            store_data,
    output logic                   dc_req,
    output logic                   dc_we,
    output logic [31:0]            dc_addr,
    output logic [3:0]             dc_wstrb,
    output logic [31:0]            dc_wdata,
    input  logic                   dc_ack,
    input  logic [31:0]            dc_rdata,
    output logic                   cache_stall,
    output logic [31:0]            load_data,
    output logic                   load_valid,
    output logic                   misaligned_exc,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic                   dcReq_q;
    logic                   dcWe_q;
    logic [31:0]            dcAddr_q;
    logic [3:0]             dcWstrb_q, dcWstrb_d;
    logic [31:0]            dcWdata_q, dcWdata_d;
    logic [2:0]             funct3_q;
    logic [1:0]             offset_q;
    logic [31:0]            loadData_q, loadData_d;
    logic                   loadValid_q;
    logic                   misalignedExc_q;
    logic [STALL_CNT_W-1:0] stallCycles_q;

    logic access;
    logic isByte;
    logic isHalf;
    logic isWord;
    logic misaligned;
    logic startAccess;
    logic ackTake;
    logic misalignedHit;
    logic stallNow;

    // Size decode: funct3[1:0] picks byte/half, everything else (incl. undefined codes) is a word
    assign access     = mem_read | mem_write;
    assign isByte     = (funct3[1:0] == 2'b00);
    assign isHalf     = (funct3[1:0] == 2'b01);
    assign isWord     = ~isByte & ~isHalf;
    assign misaligned = (isHalf & addr[0]) | (isWord & (addr[1:0] != 2'b00));

    // Next-state and handshake control; nothing is started or stalled while reset is held
    always_comb begin
        state_d       = state_q;
        stallNow      = 1'b0;
        startAccess   = 1'b0;
        ackTake       = 1'b0;
        misalignedHit = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (access) begin
                        if (misaligned) begin
                            misalignedHit = 1'b1;
                        end else begin
                            stallNow    = 1'b1;
                            startAccess = 1'b1;
                            state_d     = WAIT;
                        end
                    end
                end
                WAIT: begin
                    stallNow = 1'b1;
                    if (dc_ack) begin
                        ackTake = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Store lane placement: replicate the datum across the word, strobe only the addressed lanes
    always_comb begin
        dcWstrb_d = 4'b0000;
        dcWdata_d = 32'h0;
        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    dcWstrb_d = 4'b0001 << addr[1:0];
                    dcWdata_d = {4{store_data[7:0]}};
                end
                2'b01: begin
                    dcWstrb_d = 4'b0011 << addr[1:0];
                    dcWdata_d = {2{store_data[15:0]}};
                end
                default: begin
                    dcWstrb_d = 4'b1111;
                    dcWdata_d = store_data;
                end
            endcase
        end
    end

    // Load extraction from the returning word using the latched size and byte offset
    always_comb begin
        logic [7:0]  byteSel;
        logic [15:0] halfSel;
        byteSel    = 8'h0;
        halfSel    = offset_q[1] ? dc_rdata[31:16] : dc_rdata[15:0];
        loadData_d = dc_rdata;
        case (offset_q)
            2'd0:    byteSel = dc_rdata[7:0];
            2'd1:    byteSel = dc_rdata[15:8];
            2'd2:    byteSel = dc_rdata[23:16];
            default: byteSel = dc_rdata[31:24];
        endcase
        case (funct3_q[1:0])
            2'b00:   loadData_d = {{24{~funct3_q[2] & byteSel[7]}}, byteSel};
            2'b01:   loadData_d = {{16{~funct3_q[2] & halfSel[15]}}, halfSel};
            default: loadData_d = dc_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch: captured once when the access starts, request dropped after the ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcReq_q   <= 1'b0;
            dcWe_q    <= 1'b0;
            dcAddr_q  <= 32'h0;
            dcWstrb_q <= 4'b0000;
            dcWdata_q <= 32'h0;
            funct3_q  <= 3'b000;
            offset_q  <= 2'b00;
        end else if (startAccess) begin
            dcReq_q   <= 1'b1;
            dcWe_q    <= mem_write;
            dcAddr_q  <= {addr[31:2], 2'b00};
            dcWstrb_q <= dcWstrb_d;
            dcWdata_q <= dcWdata_d;
            funct3_q  <= funct3;
            offset_q  <= addr[1:0];
        end else if (ackTake) begin
            dcReq_q   <= 1'b0;
        end
    end

    // Load result and one-cycle pulses presented during DONE / the cycle after a misaligned access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loadData_q      <= 32'h0;
            loadValid_q     <= 1'b0;
            misalignedExc_q <= 1'b0;
        end else begin
            loadValid_q     <= ackTake & ~dcWe_q;
            misalignedExc_q <= misalignedHit;
            if (ackTake && !dcWe_q) begin
                loadData_q <= loadData_d;
            end
        end
    end

    // Saturating count of stalled cycles for performance monitoring
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCycles_q <= '0;
        end else if (stallNow && !(&stallCycles_q)) begin
            stallCycles_q <= stallCycles_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cache_stall    = stallNow;
    assign dc_req         = dcReq_q;
    assign dc_we          = dcWe_q;
    assign dc_addr        = dcAddr_q;
    assign dc_wstrb       = dcWstrb_q;
    assign dc_wdata       = dcWdata_q;
    assign load_data      = loadData_q;
    assign load_valid     = loadValid_q;
    assign misaligned_exc = misalignedExc_q;
    assign stall_cycles   = stallCycles_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        dc_req;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [3:0]  dc_wstrb;
    logic [31:0] dc_wdata;
    logic        dc_ack;
    logic [31:0] dc_rdata;
    logic        cache_stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned_exc;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    int expStall = 0;

    int          stallSeen;
    int          reqSeen;
    logic        weSeen;
    logic [31:0] addrSeen;
    logic [3:0]  wstrbSeen;
    logic [31:0] wdataSeen;
    logic        validSeen;
    logic [31:0] dataSeen;
    logic        validAfter;

    mem_access_unit #(.STALL_CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3         (funct3),
        .addr           (addr),
        .store_data     (store_data),
        .dc_req         (dc_req),
        .dc_we          (dc_we),
        .dc_addr        (dc_addr),
        .dc_wstrb       (dc_wstrb),
        .dc_wdata       (dc_wdata),
        .dc_ack         (dc_ack),
        .dc_rdata       (dc_rdata),
        .cache_stall    (cache_stall),
        .load_data      (load_data),
        .load_valid     (load_valid),
        .misaligned_exc (misaligned_exc),
        .stall_cycles   (stall_cycles)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge, then let combinational outputs settle
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] sd, input logic ack, input logic [31:0] rdata);
        @(negedge clk);
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        dc_ack     = ack;
        dc_rdata   = rdata;
        #1;
    endtask

    // One complete access: detect cycle, nWait WAIT cycles (ack on the last), DONE, optional idle cycle
    task automatic runAccess(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                             input int nWait, input logic idleAfter);
        stallSeen = 0;
        reqSeen   = 0;
        applyStimulus(rd, wr, f3, a, sd, 1'b0, rdata);
        if (cache_stall) stallSeen++;
        for (int i = 1; i <= nWait; i++) begin
            applyStimulus(rd, wr, f3, a, sd, (i == nWait), rdata);
            if (cache_stall) stallSeen++;
            if (dc_req) reqSeen++;
            if (i == 1) begin
                weSeen    = dc_we;
                addrSeen  = dc_addr;
                wstrbSeen = dc_wstrb;
                wdataSeen = dc_wdata;
            end
        end
        applyStimulus(rd, wr, f3, a, sd, 1'b0, rdata);
        if (cache_stall) stallSeen++;
        validSeen = load_valid;
        dataSeen  = load_data;
        expStall += nWait + 1;
        checkOutput({tag, " stall_len"}, stallSeen, nWait + 1);
        checkOutput({tag, " req_len"}, reqSeen, nWait);
        checkOutput({tag, " req_dropped_in_done"}, {31'h0, dc_req}, 32'h0);
        checkOutput({tag, " stall_cycles"}, stall_cycles, expStall);
        validAfter = 1'b0;
        if (idleAfter) begin
            applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0);
            validAfter = load_valid;
        end
    endtask

    initial begin
        rst        = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'b010;
        addr       = 32'h0;
        store_data = 32'h0;
        dc_ack     = 1'b0;
        dc_rdata   = 32'h0;

        // Reset state
        #12;
        checkOutput("reset dc_req", {31'h0, dc_req}, 32'h0);
        checkOutput("reset cache_stall", {31'h0, cache_stall}, 32'h0);
        checkOutput("reset load_valid", {31'h0, load_valid}, 32'h0);
        checkOutput("reset misaligned_exc", {31'h0, misaligned_exc}, 32'h0);
        checkOutput("reset stall_cycles", stall_cycles, 32'h0);
        checkOutput("reset dc_addr", dc_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // LW with ack three cycles after the request rises
        runAccess("lw_slow", 1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'hCAFE_BABE, 3, 1'b1);
        checkOutput("lw_slow dc_we", {31'h0, weSeen}, 32'h0);
        checkOutput("lw_slow dc_addr", addrSeen, 32'h0000_1000);
        checkOutput("lw_slow load_valid", {31'h0, validSeen}, 32'h1);
        checkOutput("lw_slow load_data", dataSeen, 32'hCAFE_BABE);
        checkOutput("lw_slow valid_one_cycle", {31'h0, validAfter}, 32'h0);
        checkOutput("lw_slow stall_total", stall_cycles, 32'd4);

        // Load extraction from 0x8070_6050
        runAccess("lb3", 1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h8070_6050, 1, 1'b1);
        checkOutput("lb3 load_data", dataSeen, 32'hFFFF_FF80);
        checkOutput("lb3 dc_addr", addrSeen, 32'h0000_2000);
        runAccess("lbu3", 1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'h0, 32'h8070_6050, 1, 1'b1);
        checkOutput("lbu3 load_data", dataSeen, 32'h0000_0080);
        runAccess("lh2", 1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8070_6050, 1, 1'b1);
        checkOutput("lh2 load_data", dataSeen, 32'hFFFF_8070);
        runAccess("lhu2", 1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8070_6050, 1, 1'b1);
        checkOutput("lhu2 load_data", dataSeen, 32'h0000_8070);
        runAccess("lb0", 1'b1, 1'b0, 3'b000, 32'h0000_2000, 32'h0, 32'h8070_6050, 1, 1'b1);
        checkOutput("lb0 load_data", dataSeen, 32'h0000_0050);
        checkOutput("lb0 load_valid", {31'h0, validSeen}, 32'h1);

        // Stores
        runAccess("sb1", 1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB, 32'h0, 2, 1'b1);
        checkOutput("sb1 dc_we", {31'h0, weSeen}, 32'h1);
        checkOutput("sb1 dc_addr", addrSeen, 32'h0000_3000);
        checkOutput("sb1 dc_wstrb", {28'h0, wstrbSeen}, 32'h2);
        checkOutput("sb1 dc_wdata", wdataSeen, 32'hABAB_ABAB);
        checkOutput("sb1 no_load_valid", {31'h0, validSeen | validAfter}, 32'h0);
        runAccess("sh2", 1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h0000_1234, 32'h0, 1, 1'b1);
        checkOutput("sh2 dc_wstrb", {28'h0, wstrbSeen}, 32'hC);
        checkOutput("sh2 dc_wdata", wdataSeen, 32'h1234_1234);
        checkOutput("sh2 no_load_valid", {31'h0, validSeen}, 32'h0);

        // Misaligned LW: no request, no stall, one-cycle exception pulse
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0, 1'b0, 32'h0);
        checkOutput("lw_mis cache_stall", {31'h0, cache_stall}, 32'h0);
        applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("lw_mis exc", {31'h0, misaligned_exc}, 32'h1);
        checkOutput("lw_mis dc_req", {31'h0, dc_req}, 32'h0);
        applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("lw_mis exc_drop", {31'h0, misaligned_exc}, 32'h0);

        // Misaligned SH
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_3001, 32'h0000_5555, 1'b0, 32'h0);
        checkOutput("sh_mis cache_stall", {31'h0, cache_stall}, 32'h0);
        applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("sh_mis exc", {31'h0, misaligned_exc}, 32'h1);
        checkOutput("sh_mis dc_req", {31'h0, dc_req}, 32'h0);
        checkOutput("sh_mis stall_cycles", stall_cycles, expStall);
        applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("sh_mis exc_drop", {31'h0, misaligned_exc}, 32'h0);

        // Read and write both asserted: treated as a store
        runAccess("rw_both", 1'b1, 1'b1, 3'b010, 32'h0000_4000, 32'h1122_3344, 32'hDEAD_BEEF, 1, 1'b1);
        checkOutput("rw_both dc_we", {31'h0, weSeen}, 32'h1);
        checkOutput("rw_both dc_wstrb", {28'h0, wstrbSeen}, 32'hF);
        checkOutput("rw_both dc_wdata", wdataSeen, 32'h1122_3344);
        checkOutput("rw_both no_load_valid", {31'h0, validSeen}, 32'h0);

        // Fast ack followed immediately by a second independent LW
        runAccess("b2b_first", 1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h1111_1111, 1, 1'b0);
        checkOutput("b2b_first load_data", dataSeen, 32'h1111_1111);
        runAccess("b2b_second", 1'b1, 1'b0, 3'b010, 32'h0000_6004, 32'h0, 32'h2222_2222, 1, 1'b1);
        checkOutput("b2b_second dc_addr", addrSeen, 32'h0000_6004);
        checkOutput("b2b_second load_data", dataSeen, 32'h2222_2222);
        checkOutput("b2b_second valid_one_cycle", {31'h0, validAfter}, 32'h0);
        checkOutput("b2b_second no_reissue", {31'h0, dc_req | cache_stall}, 32'h0);

        // Reset while a load is waiting for its ack
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 1'b0, 32'h3333_3333);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 1'b0, 32'h3333_3333);
        checkOutput("rst_wait dc_req_before", {31'h0, dc_req}, 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("rst_wait dc_req", {31'h0, dc_req}, 32'h0);
        checkOutput("rst_wait cache_stall", {31'h0, cache_stall}, 32'h0);
        checkOutput("rst_wait stall_cycles", stall_cycles, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_read = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 32'h3333_3333);
        applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("stray_ack load_valid", {31'h0, load_valid}, 32'h0);
        checkOutput("stray_ack dc_req", {31'h0, dc_req}, 32'h0);
        checkOutput("stray_ack stall_cycles", stall_cycles, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
